// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: decimates ADC samples into an external FIFO
// and drains it in fixed-length bursts (or fully on stop).
module adc_capture_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 64,
    parameter int DS_SHIFT   = 2,
    parameter int BURST_LEN  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          adc_valid,
    input  logic [DATA_WIDTH-1:0]         adc_data,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
    input  logic                          fifo_empty,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overflow
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BW  = $clog2(BURST_LEN) + 1;
    localparam int DSW = (DS_SHIFT > 0) ? DS_SHIFT : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DSW-1:0]          ds_cnt_q;
    logic [BW-1:0]           burst_cnt_q;
    logic                    rd_pend_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    overflow_q;

    logic capturing;
    logic ds_zero;
    logic wr_due;
    logic accept;
    logic slot_free;
    logic burst_room;
    logic rd_ok;

    always_comb begin
        capturing  = (state_q == RUN) || (state_q == BURST);
        ds_zero    = (DS_SHIFT == 0) || (ds_cnt_q == '0);
        wr_due     = capturing && adc_valid && ds_zero;
        accept     = out_valid_q && out_ready;
        slot_free  = !out_valid_q || out_ready;
        // a held word still counts against the burst until it is accepted
        burst_room = burst_cnt_q > BW'(out_valid_q);
        rd_ok      = !fifo_empty && !rd_pend_q && slot_free;
    end

    always_comb begin
        fifo_wr_en   = rst_n && wr_due && !fifo_full;
        fifo_wr_data = adc_data;
        fifo_rd_en   = rst_n && rd_ok &&
                       ((state_q == FLUSH) ||
                        ((state_q == BURST) && burst_room));
        out_valid    = out_valid_q;
        out_data     = out_data_q;
        busy         = (state_q != IDLE);
        overflow     = overflow_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (stop)
                    state_d = FLUSH;
                else if (fifo_count >= CW'(BURST_LEN))
                    state_d = BURST;
            end
            BURST: begin
                if (stop)
                    state_d = FLUSH;
                else if (burst_cnt_q == '0 && !rd_pend_q)
                    state_d = RUN;
            end
            FLUSH: begin
                if (fifo_empty && !rd_pend_q && !out_valid_q)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ds_cnt_q    <= '0;
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && start) begin
                ds_cnt_q    <= '0;
                overflow_q  <= 1'b0;
            end else if (capturing && adc_valid) begin
                ds_cnt_q <= ds_cnt_q + DSW'(1);
            end

            if (wr_due && fifo_full)
                overflow_q <= 1'b1;

            if (state_q == IDLE && start)
                burst_cnt_q <= '0;
            else if (state_q == RUN && state_d == BURST)
                burst_cnt_q <= BW'(BURST_LEN);
            else if (state_q == BURST && accept && burst_cnt_q != '0)
                burst_cnt_q <= burst_cnt_q - BW'(1);

            // read data arrives one cycle after the strobe
            rd_pend_q <= fifo_rd_en;
            if (rd_pend_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= fifo_rd_data;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
